fifo_stream_checker: RTL
========================

# fifo_stream_checker

Parametrised FIFO stream-integrity monitor. It sits beside a FIFO in the Aurora data path, on the same clock as the port it watches, and taps that port's write and read interfaces. Each accepted word is checked against the previous accepted word on the same side, either for a duplicate or for a broken increment sequence. Overflow and underflow are flagged, errors are counted, the first failing word is captured, and a one-cycle trigger drives the ILA.

## Interface

Parameters:
- `DATA_W`, default 32: width of the FIFO data words.
- `CNT_W`, default 16: width of every counter.
- `SEQ_MODE`, default 0: check rule. 0 = duplicate check; 1 = increment-sequence check.

Ports:
- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  reset; asynchronous, active-low.
- `clear_i`  in  1  synchronous clear of counters, flags, capture and history.
- `wr_en_i`  in  1  FIFO write enable.
- `wr_data_i`  in  DATA_W  FIFO write data.
- `fifo_full_i`  in  1  FIFO full.
- `rd_en_i`  in  1  FIFO read enable.
- `rd_data_i`  in  DATA_W  FIFO read data, valid when `rd_en_i` is high.
- `fifo_empty_i`  in  1  FIFO empty.
- `wr_err_o`  out  1  one-cycle pulse: write-side check failure.
- `rd_err_o`  out  1  one-cycle pulse: read-side check failure.
- `trig_o`  out  1  one-cycle pulse: OR of all error and overflow/underflow events.
- `ovf_o`  out  1  sticky: write attempted while full.
- `udf_o`  out  1  sticky: read attempted while empty.
- `wr_err_cnt_o`  out  CNT_W  write-side error count, saturating.
- `rd_err_cnt_o`  out  CNT_W  read-side error count, saturating.
- `wr_word_cnt_o`  out  CNT_W  accepted write words, wrapping.
- `rd_word_cnt_o`  out  CNT_W  accepted read words, wrapping.
- `first_err_valid_o`  out  1  capture registers hold a failing word.
- `first_err_side_o`  out  1  side of the captured failure: 0 = write, 1 = read.
- `first_err_data_o`  out  DATA_W  the failing word.
- `first_err_prev_o`  out  DATA_W  the previous accepted word on that side.

## Operation

- **Stage 1 (edge k):** register all inputs.
  - Write accepted = `wr_en_i & ~fifo_full_i`.
  - Read accepted = `rd_en_i & ~fifo_empty_i`.
  - Write event = `wr_en_i & fifo_full_i` (overflow).
  - Read event = `rd_en_i & fifo_empty_i` (underflow).
- **Stage 2 (edge k+1):** for each side independently:
  - If the side's history-valid flag is set, compare the accepted word with that side's `prev` register.
  - Failure when `SEQ_MODE`=0: word == prev.
  - Failure when `SEQ_MODE`=1: word != prev+1, computed modulo 2^DATA_W, so all-ones followed by 0 passes.
  - Then load `prev` with the word, set history-valid, and increment the word counter.
- **First word** after reset or clear on each side is never checked; it only loads history.
- **Overflow/underflow words** never touch history or word counters. They set `ovf_o`/`udf_o` and pulse `trig_o`.
- **Error counters** saturate at all-ones; the failure pulse still fires when a counter is saturated.
- **Capture** loads only while `first_err_valid_o`=0. If both sides fail on the same edge, the write side is captured.
- **`clear_i`** (sync, highest priority):
  - Zeroes counters, sticky flags, capture registers and history-valid.
  - Drops any stage-1 word in flight.
  - Forces the pulses to 0 on the next edge.
  - An event sampled on the same edge as `clear_i` is discarded.
- **Reset values** (while `reset_n_i`=0): every output 0, history-valid 0, `prev` registers 0. Deassertion is synchronised to `clk_i` by the integrating design.
- No flow control and no backpressure; the block is observe-only.

## Timing

- Latency is 2 edges from the input sample to the outputs: inputs sampled at edge k, then at edge k+1 the pulses assert and counters, sticky flags and capture update. Pulses last exactly one cycle.
- Back-to-back accepted words on every cycle are fully supported on both sides simultaneously with no loss.
- `trig_o` is asserted in the same cycle as `wr_err_o`/`rd_err_o`, or in the cycle following the overflow/underflow sample, at the same 2-edge latency.
- Asynchronous reset mid-stream clears everything immediately; in-flight words are lost.

## Test plan

- **Duplicate detection:** `SEQ_MODE`=0; write 0x10, 0x11, 0x11, 0x12 on consecutive cycles.
  - One `wr_err_o` pulse, 2 edges after the second 0x11.
  - `wr_err_cnt_o`=1, `wr_word_cnt_o`=4.
  - Capture: data=0x11, prev=0x11, side=0.
- **Sequence wrap:** `SEQ_MODE`=1, `DATA_W`=32; read 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x2.
  - Exactly one `rd_err_o`, on 0x2.
  - Capture prev=0x0, side=1.
- **Overflow/underflow:** `wr_en_i` with `fifo_full_i`=1 carrying 0x55, then a valid write of 0x55.
  - `ovf_o`=1 sticky and one `trig_o` pulse.
  - No duplicate error on the valid 0x55, because the overflowed word was not loaded into history.
  - Repeat with `rd_en_i` and `fifo_empty_i`=1: `udf_o`=1.
- **Simultaneous failures:** both sides fail on the same cycle.
  - Both pulses fire, both counters increment.
  - Capture side=0 (write).
- **Saturation:** `CNT_W`=4; 20 write duplicates.
  - `wr_err_cnt_o` holds at 0xF.
  - `wr_err_o` still pulses 19 times.
- **Clear and reset:** `clear_i` on the same cycle as a duplicate write.
  - No pulse; all counters and flags 0.
  - The next word is unchecked.
  - `reset_n_i` low mid-stream: all outputs 0 immediately.

Source files
------------

// File: rtl/fifo_stream_checker.sv
// Observe-only integrity monitor for a FIFO's write and read ports.
// Stage 1 registers the ports; stage 2 checks, counts, flags and captures.
module fifo_stream_checker #(
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16,
  parameter int SEQ_MODE = 0
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              clear_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              fifo_full_i,
  input  logic              rd_en_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              fifo_empty_i,
  output logic              wr_err_o,
  output logic              rd_err_o,
  output logic              trig_o,
  output logic              ovf_o,
  output logic              udf_o,
  output logic [CNT_W-1:0]  wr_err_cnt_o,
  output logic [CNT_W-1:0]  rd_err_cnt_o,
  output logic [CNT_W-1:0]  wr_word_cnt_o,
  output logic [CNT_W-1:0]  rd_word_cnt_o,
  output logic              first_err_valid_o,
  output logic              first_err_side_o,
  output logic [DATA_W-1:0] first_err_data_o,
  output logic [DATA_W-1:0] first_err_prev_o
);

  // Side index 0 is the write port, 1 is the read port.
  logic [1:0]        acc_in;
  logic [1:0]        evt_in;
  logic [DATA_W-1:0] data_in [2];

  logic [1:0]        fail;
  logic [1:0]        evt_s1;
  logic [1:0]        err_pulse;
  logic [1:0]        sticky;
  logic [DATA_W-1:0] word_s1 [2];
  logic [DATA_W-1:0] hist [2];
  logic [CNT_W-1:0]  err_cnt [2];
  logic [CNT_W-1:0]  word_cnt [2];

  assign acc_in[0]  = wr_en_i & ~fifo_full_i;
  assign acc_in[1]  = rd_en_i & ~fifo_empty_i;
  assign evt_in[0]  = wr_en_i & fifo_full_i;
  assign evt_in[1]  = rd_en_i & fifo_empty_i;
  assign data_in[0] = wr_data_i;
  assign data_in[1] = rd_data_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_side
      logic              s1_acc_reg;
      logic              s1_evt_reg;
      logic [DATA_W-1:0] s1_data_reg;
      logic              hist_valid_reg;
      logic [DATA_W-1:0] prev_reg;
      logic              err_pulse_reg;
      logic              sticky_reg;
      logic [CNT_W-1:0]  err_cnt_reg;
      logic [CNT_W-1:0]  word_cnt_reg;
      logic              mismatch;

      if (SEQ_MODE == 0) begin : g_dup
        assign mismatch = (s1_data_reg == prev_reg);
      end else begin : g_seq
        // DATA_W-bit arithmetic wraps, so all-ones followed by zero is a valid step.
        assign mismatch = (s1_data_reg != prev_reg + DATA_W'(1));
      end

      assign fail[gi] = s1_acc_reg & hist_valid_reg & mismatch;

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          s1_acc_reg     <= 1'b0;
          s1_evt_reg     <= 1'b0;
          s1_data_reg    <= '0;
          hist_valid_reg <= 1'b0;
          prev_reg       <= '0;
          err_pulse_reg  <= 1'b0;
          sticky_reg     <= 1'b0;
          err_cnt_reg    <= '0;
          word_cnt_reg   <= '0;
        end else if (clear_i) begin
          // Clear drops both the word in flight and the one sampled now.
          s1_acc_reg     <= 1'b0;
          s1_evt_reg     <= 1'b0;
          s1_data_reg    <= '0;
          hist_valid_reg <= 1'b0;
          prev_reg       <= '0;
          err_pulse_reg  <= 1'b0;
          sticky_reg     <= 1'b0;
          err_cnt_reg    <= '0;
          word_cnt_reg   <= '0;
        end else begin
          s1_acc_reg    <= acc_in[gi];
          s1_evt_reg    <= evt_in[gi];
          s1_data_reg   <= data_in[gi];
          err_pulse_reg <= fail[gi];
          if (s1_acc_reg) begin
            prev_reg       <= s1_data_reg;
            hist_valid_reg <= 1'b1;
            word_cnt_reg   <= word_cnt_reg + CNT_W'(1);
          end
          if (fail[gi] && (err_cnt_reg != {CNT_W{1'b1}})) begin
            err_cnt_reg <= err_cnt_reg + CNT_W'(1);
          end
          if (s1_evt_reg) begin
            sticky_reg <= 1'b1;
          end
        end
      end

      assign evt_s1[gi]    = s1_evt_reg;
      assign err_pulse[gi] = err_pulse_reg;
      assign sticky[gi]    = sticky_reg;
      assign word_s1[gi]   = s1_data_reg;
      assign hist[gi]      = prev_reg;
      assign err_cnt[gi]   = err_cnt_reg;
      assign word_cnt[gi]  = word_cnt_reg;
    end
  endgenerate

  logic              trig_reg;
  logic              cap_valid_reg;
  logic              cap_side_reg;
  logic [DATA_W-1:0] cap_data_reg;
  logic [DATA_W-1:0] cap_prev_reg;
  logic              cap_valid_next;
  logic              cap_side_next;
  logic [DATA_W-1:0] cap_data_next;
  logic [DATA_W-1:0] cap_prev_next;

  // Capture is one-shot; the write side wins a same-edge tie.
  always_comb begin
    cap_valid_next = cap_valid_reg;
    cap_side_next  = cap_side_reg;
    cap_data_next  = cap_data_reg;
    cap_prev_next  = cap_prev_reg;
    if (!cap_valid_reg && (fail != 2'b00)) begin
      cap_valid_next = 1'b1;
      if (fail[0]) begin
        cap_side_next = 1'b0;
        cap_data_next = word_s1[0];
        cap_prev_next = hist[0];
      end else begin
        cap_side_next = 1'b1;
        cap_data_next = word_s1[1];
        cap_prev_next = hist[1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      trig_reg      <= 1'b0;
      cap_valid_reg <= 1'b0;
      cap_side_reg  <= 1'b0;
      cap_data_reg  <= '0;
      cap_prev_reg  <= '0;
    end else if (clear_i) begin
      trig_reg      <= 1'b0;
      cap_valid_reg <= 1'b0;
      cap_side_reg  <= 1'b0;
      cap_data_reg  <= '0;
      cap_prev_reg  <= '0;
    end else begin
      trig_reg      <= (|fail) | (|evt_s1);
      cap_valid_reg <= cap_valid_next;
      cap_side_reg  <= cap_side_next;
      cap_data_reg  <= cap_data_next;
      cap_prev_reg  <= cap_prev_next;
    end
  end

  assign wr_err_o          = err_pulse[0];
  assign rd_err_o          = err_pulse[1];
  assign trig_o            = trig_reg;
  assign ovf_o             = sticky[0];
  assign udf_o             = sticky[1];
  assign wr_err_cnt_o      = err_cnt[0];
  assign rd_err_cnt_o      = err_cnt[1];
  assign wr_word_cnt_o     = word_cnt[0];
  assign rd_word_cnt_o     = word_cnt[1];
  assign first_err_valid_o = cap_valid_reg;
  assign first_err_side_o  = cap_side_reg;
  assign first_err_data_o  = cap_data_reg;
  assign first_err_prev_o  = cap_prev_reg;

endmodule
